dmem_mmio_responder: RTL and testbench

- Responder end of the core's data-memory interface: accepts the memory stage's address, write data, write enable and byte-lane pattern, and returns read data in the same cycle.
- Decodes each access to one of three targets:
  - word RAM with byte-lane writes;
  - a small MMIO block holding a 64-bit cycle timer, a compare/interrupt register and a console transmit FIFO;
  - unmapped space.
- Sits beside the pipeline in the SoC top; the console side drives an external valid/ready byte sink.

---
 rtl/dmem_mmio_responder_pkg.sv | 21 ++
 rtl/dmem_mmio_responder_tx_fifo.sv | 79 +++++++
 rtl/dmem_mmio_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets and STATUS bit positions.
// Offsets are word offsets within the 32-byte MMIO window (addr[4:2]).
package dmem_mmio_responder_pkg;

    typedef enum logic [2:0] {
        MMIO_MTIME_LO = 3'd0,
        MMIO_MTIME_HI = 3'd1,
        MMIO_MTIMECMP = 3'd2,
        MMIO_STATUS   = 3'd3,
        MMIO_TXDATA   = 3'd4
    } mmioReg_e;

    localparam int STAT_TXFULL  = 0;
    localparam int STAT_TXEMPTY = 1;
    localparam int STAT_IRQ     = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_BUSERR  = 4;

    localparam logic [31:0] MTIMECMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Console transmit FIFO: 8-bit entries, registered head byte, drops pushes that find it full
// unless a pop frees a slot on the same edge.
module tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] pushData,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic       dropped,
    output logic [7:0] headData
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtrNext;
    logic [CW-1:0] count;
    logic [CW-1:0] countNext;
    logic          doPush;
    logic          doPop;
    logic [7:0]    headNext;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        doPop     = pop && !empty;
        doPush    = push && (!full || doPop);
        dropped   = push && !doPush;
        rdPtrNext = doPop ? rdPtr + 1'b1 : rdPtr;
        countNext = count;
        case ({doPush, doPop})
            2'b10:   countNext = count + 1'b1;
            2'b01:   countNext = count - 1'b1;
            default: countNext = count;
        endcase
        // The byte landing in the new head slot this edge is not in mem yet; forward it.
        headNext = mem[rdPtrNext];
        if (doPush && (wrPtr == rdPtrNext)) begin
            headNext = pushData;
        end
        if (countNext == '0) begin
            headNext = '0;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            headData <= '0;
        end else begin
            rdPtr    <= rdPtrNext;
            count    <= countNext;
            headData <= headNext;
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
        end
    end

    // NOTE: storage arrays are not reset; the cleared pointers and count already make them invisible.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM with byte-lane stores, a timer/compare/console MMIO block,
// and unmapped space that reads zero and flags stores as bus errors.
module dmem_mmio_responder
    import dmem_mmio_responder_pkg::*;
#(
    parameter int          RAM_AW     = 10,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [3:0]  amp,
    output logic [31:0] rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        timer_irq
);

    logic [31:0]       ram [2**RAM_AW];
    logic              ramSel;
    logic              mmioSel;
    logic              unmappedSel;
    logic [RAM_AW-1:0] wordIdx;
    logic [2:0]        regOff;
    logic              unusedAddrLsbs;

    logic [63:0] mtime;
    logic [31:0] mtimecmp;
    logic        armed;
    logic        cmpHit;
    logic        irqPending;
    logic        timerIrqQ;
    logic        txOverflow;
    logic        busError;
    logic [31:0] statusWord;

    logic cmpWrite;
    logic statWrite;
    logic txPush;
    logic txPop;
    logic busErrSet;
    logic fifoFull;
    logic fifoEmpty;
    logic fifoDropped;

    assign ramSel         = (addr[31:RAM_AW+2] == '0);
    assign mmioSel        = (addr[31:5] == MMIO_BASE[31:5]);
    assign unmappedSel    = !ramSel && !mmioSel;
    assign wordIdx        = addr[RAM_AW+1:2];
    assign regOff         = addr[4:2];
    assign unusedAddrLsbs = ^addr[1:0];

    assign cmpWrite  = we && mmioSel && (regOff == MMIO_MTIMECMP) && (amp == 4'b1111);
    assign statWrite = we && mmioSel && (regOff == MMIO_STATUS) && amp[0];
    assign txPush    = we && mmioSel && (regOff == MMIO_TXDATA) && amp[0];
    assign busErrSet = we && unmappedSel && (amp != 4'b0000);

    assign cmpHit     = (mtime[31:0] >= mtimecmp);
    assign irqPending = armed && cmpHit;

    always_ff @(posedge clk) begin
        if (we && ramSel) begin
            for (int i = 0; i < 4; i++) begin
                if (amp[i]) begin
                    ram[wordIdx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime      <= '0;
            mtimecmp   <= MTIMECMP_RESET;
            armed      <= 1'b0;
            timerIrqQ  <= 1'b0;
            txOverflow <= 1'b0;
            busError   <= 1'b0;
        end else begin
            mtime     <= mtime + 64'd1;
            timerIrqQ <= irqPending;

            if (cmpWrite) begin
                mtimecmp <= wdata;
                armed    <= 1'b1;
            end else if (statWrite && wdata[STAT_IRQ]) begin
                armed <= 1'b0;
            end

            if (fifoDropped) begin
                txOverflow <= 1'b1;
            end else if (statWrite && wdata[STAT_OVF]) begin
                txOverflow <= 1'b0;
            end

            if (busErrSet) begin
                busError <= 1'b1;
            end else if (statWrite && wdata[STAT_BUSERR]) begin
                busError <= 1'b0;
            end
        end
    end

    always_comb begin
        statusWord               = '0;
        statusWord[STAT_TXFULL]  = fifoFull;
        statusWord[STAT_TXEMPTY] = fifoEmpty;
        statusWord[STAT_IRQ]     = irqPending;
        statusWord[STAT_OVF]     = txOverflow;
        statusWord[STAT_BUSERR]  = busError;
    end

    always_comb begin
        rdata = '0;
        if (ramSel) begin
            rdata = ram[wordIdx];
        end else if (mmioSel) begin
            case (regOff)
                MMIO_MTIME_LO: rdata = mtime[31:0];
                MMIO_MTIME_HI: rdata = mtime[63:32];
                MMIO_MTIMECMP: rdata = mtimecmp;
                MMIO_STATUS:   rdata = statusWord;
                default:       rdata = '0;
            endcase
        end
    end

    assign txPop = !fifoEmpty && tx_ready;

    tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) txFifo (
        .clk     (clk),
        .reset   (reset),
        .push    (txPush),
        .pushData(wdata[7:0]),
        .pop     (txPop),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .dropped (fifoDropped),
        .headData(tx_data)
    );

    assign tx_valid  = !fifoEmpty;
    assign timer_irq = timerIrqQ;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Randomized bench for dmem_mmio_responder: behavioural model of RAM, timer and console FIFO,
// a byte scoreboard for the transmit stream, and a negedge monitor comparing every output.
module tb_dmem_mmio_responder;

    localparam int          RAM_AW = 10;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] BASE   = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic [3:0]  amp = '0;
    logic [31:0] rdata;
    logic        txValid;
    logic [7:0]  txData;
    logic        txReady = 1'b0;
    logic        timerIrq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_mmio_responder #(
        .RAM_AW    (RAM_AW),
        .FIFO_DEPTH(DEPTH),
        .MMIO_BASE (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .amp      (amp),
        .rdata    (rdata),
        .tx_valid (txValid),
        .tx_data  (txData),
        .tx_ready (txReady),
        .timer_irq(timerIrq)
    );

    // Reference model state
    logic [31:0] ramM [int];
    logic [63:0] mtimeM = '0;
    logic [31:0] cmpM = 32'hFFFF_FFFF;
    bit          armedM = 1'b0;
    bit          irqM = 1'b0;
    bit          ovfM = 1'b0;
    bit          berrM = 1'b0;
    int          cntM = 0;
    logic [7:0]  sbQ[$];
    bit          popM;
    logic [31:0] tmpWord;
    int          idxM;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit isRam(input logic [31:0] a);
        return a[31:RAM_AW+2] == '0;
    endfunction

    function automatic bit isMmio(input logic [31:0] a);
        return a[31:5] == BASE[31:5];
    endfunction

    function automatic logic [31:0] statusM();
        logic [31:0] s;
        s = '0;
        s[0] = (cntM == DEPTH);
        s[1] = (cntM == 0);
        s[2] = armedM && (mtimeM[31:0] >= cmpM);
        s[3] = ovfM;
        s[4] = berrM;
        return s;
    endfunction

    function automatic bit expRead(input logic [31:0] a, output logic [31:0] v);
        int i;
        v = '0;
        if (isRam(a)) begin
            i = int'(a[RAM_AW+1:2]);
            if (!ramM.exists(i)) return 1'b0;
            v = ramM[i];
            return !$isunknown(v);
        end
        if (isMmio(a)) begin
            case (a[4:2])
                3'd0:    v = mtimeM[31:0];
                3'd1:    v = mtimeM[63:32];
                3'd2:    v = cmpM;
                3'd3:    v = statusM();
                default: v = '0;
            endcase
        end
        return 1'b1;
    endfunction

    // Model: advances on every rising edge from the inputs the bench applied for that cycle.
    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            mtimeM = '0;
            cmpM   = 32'hFFFF_FFFF;
            armedM = 1'b0;
            irqM   = 1'b0;
            ovfM   = 1'b0;
            berrM  = 1'b0;
            cntM   = 0;
            sbQ.delete();
        end else begin
            irqM = armedM && (mtimeM[31:0] >= cmpM);
            popM = (cntM > 0) && txReady;
            if (we && isRam(addr)) begin
                idxM    = int'(addr[RAM_AW+1:2]);
                tmpWord = ramM.exists(idxM) ? ramM[idxM] : 'x;
                for (int i = 0; i < 4; i++) begin
                    if (amp[i]) tmpWord[8*i +: 8] = wdata[8*i +: 8];
                end
                ramM[idxM] = tmpWord;
            end
            if (we && isMmio(addr)) begin
                case (addr[4:2])
                    3'd2: if (amp == 4'hF) begin
                        cmpM   = wdata;
                        armedM = 1'b1;
                    end
                    3'd3: if (amp[0]) begin
                        if (wdata[2]) armedM = 1'b0;
                        if (wdata[3]) ovfM = 1'b0;
                        if (wdata[4]) berrM = 1'b0;
                    end
                    3'd4: if (amp[0]) begin
                        if (cntM < DEPTH || popM) begin
                            sbQ.push_back(wdata[7:0]);
                            cntM++;
                        end else begin
                            ovfM = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (we && !isRam(addr) && !isMmio(addr) && amp != 4'b0000) berrM = 1'b1;
            if (popM) cntM--;
            mtimeM = mtimeM + 64'd1;
        end
    end

    // Monitor: compares all outputs half a cycle after each edge.
    initial forever begin
        logic [7:0]  expByte;
        logic [31:0] expWord;
        @(negedge clk);
        check("tx_valid", 32'(txValid), 32'(cntM > 0));
        if (cntM == 0) check("tx_data_idle", 32'(txData), 32'h0);
        if (txValid && txReady) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_pop: handshake with no byte expected, tx_data=%h at %0t", txData, $time);
            end else begin
                expByte = sbQ.pop_front();
                check("tx_data", 32'(txData), 32'(expByte));
            end
        end
        check("timer_irq", 32'(timerIrq), 32'(irqM));
        if (expRead(addr, expWord)) check("rdata", rdata, expWord);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr = a; wdata = d; we = 1'b1; amp = m;
        cyc();
        we = 1'b0; amp = '0;
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a; we = 1'b0; amp = '0;
        cyc();
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        addr = a; we = 1'b0; amp = '0;
        #1;
        v = rdata;
        cyc();
    endtask

    function automatic logic [31:0] ramAddr();
        return 32'h100 + 4 * $urandom_range(0, 15);
    endfunction

    initial begin
        logic [31:0] v;
        logic [7:0]  seq [4];
        bit          found;
        int          op;
        int          offs;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(txValid), 32'h0);
        check("rst_tx_data", 32'(txData), 32'h0);
        check("rst_timer_irq", 32'(timerIrq), 32'h0);
        peek(BASE + 32'hC, v);
        check("rst_status", v, 32'h2);
        reset = 1'b1;

        // Timer compare: cmp written on the first edge after release
        wr(BASE + 32'h8, 32'd20, 4'hF);
        addr  = BASE;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            #1;
            if (timerIrq) begin
                found = 1'b1;
                check("irq_rise_mtime", rdata, 32'd21);
            end else begin
                cyc();
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL irq_rise: timer_irq never asserted");
        end
        cyc();
        wr(BASE + 32'hC, 32'h4, 4'b0001);
        check("irq_hold", 32'(timerIrq), 32'h1);
        cyc();
        check("irq_fall", 32'(timerIrq), 32'h0);
        peek(BASE + 32'hC, v);
        check("status_irq_clear", 32'(v[2]), 32'h0);

        // Byte-lane store
        wr(32'h40, 32'h1122_3344, 4'hF);
        wr(32'h42, 32'hAAAA_AAAA, 4'b0100);
        peek(32'h40, v);
        check("ram_byte_lane", v, 32'h11AA_3344);

        // FIFO fill past capacity, then drain
        txReady = 1'b0;
        for (int i = 0; i < 5; i++) wr(BASE + 32'h10, 32'h41 + i, 4'b0001);
        peek(BASE + 32'hC, v);
        check("status_full_ovf", v, 32'h9);
        txReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_seq", 32'(txData), 32'h41 + i);
            cyc();
        end
        check("drain_done", 32'(txValid), 32'h0);
        peek(BASE + 32'hC, v);
        check("status_empty", 32'(v[1]), 32'h1);
        wr(BASE + 32'hC, 32'h8, 4'b0001);

        // Push into a full FIFO while it pops
        txReady = 1'b0;
        for (int i = 0; i < 4; i++) wr(BASE + 32'h10, 32'h50 + i, 4'b0001);
        txReady = 1'b1;
        wr(BASE + 32'h10, 32'h55, 4'b0001);
        seq = '{8'h51, 8'h52, 8'h53, 8'h55};
        for (int i = 0; i < 4; i++) begin
            check("full_pushpop_seq", 32'(txData), 32'(seq[i]));
            cyc();
        end
        peek(BASE + 32'hC, v);
        check("full_pushpop_no_ovf", 32'(v[3]), 32'h0);

        // Unmapped space
        peek(32'h8000_0000, v);
        check("unmapped_read", v, 32'h0);
        wr(32'h8000_0000, $urandom, 4'hF);
        peek(BASE + 32'hC, v);
        check("bus_error_set", 32'(v[4]), 32'h1);
        wr(BASE + 32'hC, 32'h10, 4'b0001);
        peek(BASE + 32'hC, v);
        check("bus_error_clear", 32'(v[4]), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 16; i++) wr(32'h100 + 4 * i, $urandom, 4'hF);
        for (int n = 0; n < 1500; n++) begin
            txReady = ($urandom_range(0, 1) == 1);
            op = $urandom_range(0, 9);
            case (op)
                0, 1: wr(ramAddr(), $urandom, 4'($urandom_range(0, 15)));
                2: rd(ramAddr());
                3: rd(BASE + 4 * $urandom_range(0, 7));
                4: wr(BASE + 32'h10, $urandom, 4'($urandom_range(0, 15)));
                5: wr(BASE + 32'hC, $urandom_range(0, 31), 4'($urandom_range(0, 15)));
                6: wr(BASE + 32'h8, mtimeM[31:0] + $urandom_range(0, 30),
                      ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15)));
                7: begin
                    v = 32'h8000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
                    if ($urandom_range(0, 1) == 1) wr(v, $urandom, 4'($urandom_range(0, 15)));
                    else rd(v);
                end
                default: begin
                    offs = $urandom_range(0, 4);
                    if (offs >= 2) offs = offs + 3;
                    wr(BASE + 4 * offs, $urandom, 4'hF);
                end
            endcase
        end

        // Reset in the middle of a drain
        txReady = 1'b1;
        for (int i = 0; i < 20 && cntM > 0; i++) cyc();
        check("pre_reset_empty", 32'(txValid), 32'h0);
        txReady = 1'b0;
        for (int i = 0; i < 4; i++) wr(BASE + 32'h10, 32'h61 + i, 4'b0001);
        txReady = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        check("midrst_tx_valid", 32'(txValid), 32'h0);
        check("midrst_tx_data", 32'(txData), 32'h0);
        check("midrst_timer_irq", 32'(timerIrq), 32'h0);
        peek(BASE, v);
        check("midrst_mtime_lo", v, 32'h0);
        peek(BASE + 32'h4, v);
        check("midrst_mtime_hi", v, 32'h0);
        reset = 1'b1;
        peek(BASE + 32'hC, v);
        check("post_rst_status", v, 32'h2);
        txReady = 1'b0;
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
